// File: rtl/mips_defs.sv
// Shared MIPS datapath constants: default widths, well-known register
// indices and the reset values of the stack and global pointers.
package mips_defs;

   localparam int LARGURA_PADRAO    = 32;
   localparam int N_REG_BITS_PADRAO = 5;

   localparam int REG_ZERO = 0;
   localparam int REG_GP   = 28;
   localparam int REG_SP   = 29;
   localparam int REG_RA   = 31;

   localparam logic [31:0] SP_INIT_PADRAO = 32'h0000_3FFC;
   localparam logic [31:0] GP_INIT_PADRAO = 32'h0000_1800;

endpackage

// File: rtl/banco_registradores_if.sv
// Decode-stage register file bus: two operand read ports, one debug read
// port and the write-back port.
interface banco_registradores_if #(
   parameter int LARGURA    = 32,
   parameter int N_REG_BITS = 5
);
   // No valid/ready pair: reads are purely combinational from the address,
   // and a write is one beat qualified by escreveReg at the rising clock edge.
   logic [N_REG_BITS-1:0] regLe1;
   logic [N_REG_BITS-1:0] regLe2;
   logic [N_REG_BITS-1:0] regEscrita;
   logic [LARGURA-1:0]    dadosEscrita;
   logic                  escreveReg;
   logic [N_REG_BITS-1:0] regDbg;
   logic [LARGURA-1:0]    dadosLe1;
   logic [LARGURA-1:0]    dadosLe2;
   logic [LARGURA-1:0]    dadosDbg;

   modport master (
      output regLe1, regLe2, regEscrita, dadosEscrita, escreveReg, regDbg,
      input  dadosLe1, dadosLe2, dadosDbg
   );

   modport slave (
      input  regLe1, regLe2, regEscrita, dadosEscrita, escreveReg, regDbg,
      output dadosLe1, dadosLe2, dadosDbg
   );

endinterface

// File: rtl/porta_leitura_bypass.sv
// One combinational read port: forces $zero to read 0 and optionally
// forwards a same-cycle write to the reader.
module porta_leitura_bypass
   import mips_defs::*;
#(
   parameter int LARGURA    = LARGURA_PADRAO,
   parameter int N_REG_BITS = N_REG_BITS_PADRAO,
   parameter int BYPASS     = 1
) (
   input  logic [N_REG_BITS-1:0] endereco_i,
   input  logic [LARGURA-1:0]    dado_armazenado_i,
   input  logic [N_REG_BITS-1:0] reg_escrita_i,
   input  logic [LARGURA-1:0]    dados_escrita_i,
   input  logic                  escreve_reg_i,
   input  logic                  rst_i,
   output logic [LARGURA-1:0]    dado_o
);

   localparam logic [N_REG_BITS-1:0] ENDERECO_ZERO = N_REG_BITS'(REG_ZERO);

   logic encaminha;

   // Reset suppresses forwarding so outputs track the cleared storage.
   assign encaminha = (BYPASS != 0) && escreve_reg_i && !rst_i &&
                      (reg_escrita_i != ENDERECO_ZERO) &&
                      (endereco_i == reg_escrita_i);

   always_comb begin
      dado_o = dado_armazenado_i;
      if (endereco_i == ENDERECO_ZERO) begin
         dado_o = '0;
      end else if (encaminha) begin
         dado_o = dados_escrita_i;
      end
   end

endmodule

// File: rtl/banco_registradores.sv
// MIPS 32x32 general-purpose register file: asynchronous reset with $gp/$sp
// presets, edge-triggered write, two operand ports and one debug port.
module banco_registradores
   import mips_defs::*;
#(
   parameter int                LARGURA    = LARGURA_PADRAO,
   parameter int                N_REG_BITS = N_REG_BITS_PADRAO,
   parameter int                BYPASS     = 1,
   parameter logic [LARGURA-1:0] SP_INIT   = LARGURA'(SP_INIT_PADRAO),
   parameter logic [LARGURA-1:0] GP_INIT   = LARGURA'(GP_INIT_PADRAO)
) (
   input logic                  clk,
   input logic                  rst,
   banco_registradores_if.slave bus
);

   localparam int NUM_REG = 2 ** N_REG_BITS;
   localparam logic [N_REG_BITS-1:0] ENDERECO_ZERO = N_REG_BITS'(REG_ZERO);

   logic [LARGURA-1:0] regs_q [NUM_REG];
   logic               escrita_valida;
   logic [LARGURA-1:0] le1_w;
   logic [LARGURA-1:0] le2_w;
   logic [LARGURA-1:0] dbg_w;

   function automatic logic [LARGURA-1:0] valor_reset(input int idx);
      if (idx == REG_GP) return GP_INIT;
      if (idx == REG_SP) return SP_INIT;
      return '0;
   endfunction

   assign escrita_valida = bus.escreveReg && (bus.regEscrita != ENDERECO_ZERO);

   // Register 0 is never written, so it stays 0 from reset onward.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REG; i++) begin
            regs_q[i] <= valor_reset(i);
         end
      end else if (escrita_valida) begin
         regs_q[bus.regEscrita] <= bus.dadosEscrita;
      end
   end

   porta_leitura_bypass #(
      .LARGURA(LARGURA), .N_REG_BITS(N_REG_BITS), .BYPASS(BYPASS)
   ) u_porta_a (
      .endereco_i       (bus.regLe1),
      .dado_armazenado_i(regs_q[bus.regLe1]),
      .reg_escrita_i    (bus.regEscrita),
      .dados_escrita_i  (bus.dadosEscrita),
      .escreve_reg_i    (bus.escreveReg),
      .rst_i            (rst),
      .dado_o           (le1_w)
   );

   porta_leitura_bypass #(
      .LARGURA(LARGURA), .N_REG_BITS(N_REG_BITS), .BYPASS(BYPASS)
   ) u_porta_b (
      .endereco_i       (bus.regLe2),
      .dado_armazenado_i(regs_q[bus.regLe2]),
      .reg_escrita_i    (bus.regEscrita),
      .dados_escrita_i  (bus.dadosEscrita),
      .escreve_reg_i    (bus.escreveReg),
      .rst_i            (rst),
      .dado_o           (le2_w)
   );

   // The debug port always shows committed state, never the pending write.
   porta_leitura_bypass #(
      .LARGURA(LARGURA), .N_REG_BITS(N_REG_BITS), .BYPASS(0)
   ) u_porta_dbg (
      .endereco_i       (bus.regDbg),
      .dado_armazenado_i(regs_q[bus.regDbg]),
      .reg_escrita_i    (bus.regEscrita),
      .dados_escrita_i  (bus.dadosEscrita),
      .escreve_reg_i    (bus.escreveReg),
      .rst_i            (rst),
      .dado_o           (dbg_w)
   );

   assign bus.dadosLe1 = le1_w;
   assign bus.dadosLe2 = le2_w;
   assign bus.dadosDbg = dbg_w;

endmodule

// File: tb/tb_banco_registradores.sv
// Directed bench for the register file: one instance with write-through
// bypass (dut_a) and one without (dut_b), driven with identical stimulus.
module tb_banco_registradores;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   banco_registradores_if #(.LARGURA(32), .N_REG_BITS(5)) if_a ();
   banco_registradores_if #(.LARGURA(32), .N_REG_BITS(5)) if_b ();

   banco_registradores #(.BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
   banco_registradores #(.BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [4:0] le1, input logic [4:0] le2,
                        input logic [4:0] esc, input logic [31:0] dat,
                        input logic we, input logic [4:0] dbg);
      if_a.regLe1 = le1; if_a.regLe2 = le2; if_a.regEscrita = esc;
      if_a.dadosEscrita = dat; if_a.escreveReg = we; if_a.regDbg = dbg;
      if_b.regLe1 = le1; if_b.regLe2 = le2; if_b.regEscrita = esc;
      if_b.dadosEscrita = dat; if_b.escreveReg = we; if_b.regDbg = dbg;
   endtask

   task automatic set_we(input logic we);
      if_a.escreveReg = we;
      if_b.escreveReg = we;
   endtask

   // Write one register on the next rising edge, then drop escreveReg.
   task automatic write_reg(input logic [4:0] esc, input logic [31:0] dat);
      @(negedge clk);
      drive(5'd0, 5'd0, esc, dat, 1'b1, 5'd0);
      @(posedge clk);
      #1 set_we(1'b0);
   endtask

   // ---------------- scoreboard ----------------
   task automatic check(input string nome, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nome, act, exp);
      end
   endtask

   function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                       input logic [3:0] ctl);
      case (ctl)
         4'd0:    return a & b;
         4'd1:    return a | b;
         4'd2:    return a + b;
         4'd6:    return a - b;
         4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   typedef struct {
      string       nome;
      logic [4:0]  le1;
      logic [4:0]  le2;
      logic [4:0]  esc;
      logic [31:0] dat;
      logic        we;
      logic [4:0]  dbg;
      logic [31:0] exp1_a;
      logic [31:0] exp2_a;
      logic [31:0] exp1_b;
      logic [31:0] exp2_b;
      logic [31:0] exp_dbg;
   } vec_t;

   vec_t vecs[6];

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0] exp_v;
      logic [31:0] res;
      total = 0;
      bad   = 0;

      // Stored state when the table runs: r5=DEADBEEF, r7=22, r28/r29 presets.
      vecs[0] = '{"tbl_read_mix", 5'd5, 5'd7, 5'd0, 32'h0, 1'b0, 5'd29,
                  32'hDEADBEEF, 32'h22, 32'hDEADBEEF, 32'h22, 32'h3FFC};
      vecs[1] = '{"tbl_bypass_a_only", 5'd3, 5'd5, 5'd3, 32'hAAAA5555, 1'b1, 5'd3,
                  32'hAAAA5555, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
      vecs[2] = '{"tbl_gp_no_we", 5'd28, 5'd28, 5'd28, 32'hCAFE, 1'b0, 5'd28,
                  32'h1800, 32'h1800, 32'h1800, 32'h1800, 32'h1800};
      vecs[3] = '{"tbl_zero_no_fwd", 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
      vecs[4] = '{"tbl_ra_fwd_sp", 5'd31, 5'd29, 5'd31, 32'h12345678, 1'b1, 5'd31,
                  32'h12345678, 32'h3FFC, 32'h0, 32'h3FFC, 32'h0};
      vecs[5] = '{"tbl_same_addr", 5'd7, 5'd7, 5'd7, 32'h99, 1'b1, 5'd7,
                  32'h99, 32'h99, 32'h22, 32'h22, 32'h22};

      // Reset held two cycles with a write pending that must be ignored.
      rst = 1'b1;
      drive(5'd28, 5'd29, 5'd4, 32'hFFFF_0000, 1'b1, 5'd4);
      repeat (2) @(posedge clk);
      #1;
      check("rst_le1_gp", if_a.dadosLe1, 32'h1800);
      check("rst_le2_sp", if_a.dadosLe2, 32'h3FFC);
      check("rst_dbg_ignored_write", if_a.dadosDbg, 32'h0);
      @(negedge clk);
      set_we(1'b0);
      rst = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if_a.regDbg = 5'(i);
         if_b.regDbg = 5'(i);
         #1;
         exp_v = (i == 28) ? 32'h1800 : (i == 29) ? 32'h3FFC : 32'h0;
         check($sformatf("rst_sweep_a_r%0d", i), if_a.dadosDbg, exp_v);
         check($sformatf("rst_sweep_b_r%0d", i), if_b.dadosDbg, exp_v);
      end

      // Basic write then hold with escreveReg low.
      write_reg(5'd5, 32'hDEADBEEF);
      drive(5'd5, 5'd5, 5'd5, 32'h1, 1'b0, 5'd5);
      #1;
      check("wr_le1_a", if_a.dadosLe1, 32'hDEADBEEF);
      check("wr_le2_a", if_a.dadosLe2, 32'hDEADBEEF);
      check("wr_le1_b", if_b.dadosLe1, 32'hDEADBEEF);
      @(posedge clk);
      #1;
      check("hold_le1_a", if_a.dadosLe1, 32'hDEADBEEF);
      check("hold_dbg_b", if_b.dadosDbg, 32'hDEADBEEF);

      // Register zero: write attempt, no forwarding, nothing stored.
      @(negedge clk);
      drive(5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
      #1;
      check("zero_fwd_le1_a", if_a.dadosLe1, 32'h0);
      check("zero_fwd_le2_a", if_a.dadosLe2, 32'h0);
      @(posedge clk);
      #1;
      check("zero_le1_a", if_a.dadosLe1, 32'h0);
      check("zero_le2_b", if_b.dadosLe2, 32'h0);
      check("zero_dbg_a", if_a.dadosDbg, 32'h0);
      set_we(1'b0);

      // Bypass vs stored read on a same-cycle write of reg7.
      write_reg(5'd7, 32'h11);
      @(negedge clk);
      drive(5'd7, 5'd0, 5'd7, 32'h22, 1'b1, 5'd7);
      #1;
      check("byp_le1_a_pre", if_a.dadosLe1, 32'h22);
      check("byp_dbg_a_pre", if_a.dadosDbg, 32'h11);
      check("nobyp_le1_b_pre", if_b.dadosLe1, 32'h11);
      @(posedge clk);
      #1;
      set_we(1'b0);
      #1;
      check("byp_dbg_a_post", if_a.dadosDbg, 32'h22);
      check("nobyp_le1_b_post", if_b.dadosLe1, 32'h22);

      // Table of combinational reads; escreveReg dropped before any edge.
      for (int v = 0; v < 6; v++) begin
         @(negedge clk);
         drive(vecs[v].le1, vecs[v].le2, vecs[v].esc, vecs[v].dat,
               vecs[v].we, vecs[v].dbg);
         #1;
         check({vecs[v].nome, "_le1_a"}, if_a.dadosLe1, vecs[v].exp1_a);
         check({vecs[v].nome, "_le2_a"}, if_a.dadosLe2, vecs[v].exp2_a);
         check({vecs[v].nome, "_le1_b"}, if_b.dadosLe1, vecs[v].exp1_b);
         check({vecs[v].nome, "_le2_b"}, if_b.dadosLe2, vecs[v].exp2_b);
         check({vecs[v].nome, "_dbg_a"}, if_a.dadosDbg, vecs[v].exp_dbg);
         set_we(1'b0);
      end

      // Mid-cycle reset: cleared without a clock, bypass suppressed.
      @(negedge clk);
      drive(5'd5, 5'd7, 5'd5, 32'h77, 1'b1, 5'd29);
      #2 rst = 1'b1;
      #1;
      check("midrst_le1_a", if_a.dadosLe1, 32'h0);
      check("midrst_le2_b", if_b.dadosLe2, 32'h0);
      check("midrst_dbg_sp", if_a.dadosDbg, 32'h3FFC);
      @(posedge clk);
      #1;
      check("midrst_write_ignored", if_a.dadosLe1, 32'h0);

      // Reset collision: rst rises in the cycle of the reg9 write.
      @(negedge clk);
      rst = 1'b0;
      drive(5'd9, 5'd9, 5'd9, 32'h55, 1'b1, 5'd9);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      check("coll_dbg_a", if_a.dadosDbg, 32'h0);
      check("coll_dbg_b", if_b.dadosDbg, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(5'd9, 5'd9, 5'd9, 32'h66, 1'b1, 5'd9);
      @(posedge clk);
      #1;
      set_we(1'b0);
      #1;
      check("first_write_a", if_a.dadosDbg, 32'h66);
      check("first_write_b", if_b.dadosLe1, 32'h66);

      // ALU operands straight from ports A and B.
      write_reg(5'd8, 32'd20);
      write_reg(5'd9, 32'd7);
      @(negedge clk);
      drive(5'd8, 5'd9, 5'd0, 32'h0, 1'b0, 5'd8);
      #1;
      res = alu(if_a.dadosLe1, if_a.dadosLe2, 4'd6);
      check("alu_sub", res, 32'd13);
      check("alu_zero", {31'd0, res == 32'd0}, 32'd0);
      res = alu(if_b.dadosLe1, if_b.dadosLe2, 4'd7);
      check("alu_slt", res, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/banco_registradores.md
Name: banco_registradores

Overview:
- MIPS 32x32-bit general-purpose register file in the datapath decode stage.
- Port A read data drives the ALU's first operand (dadosLe1) directly.
- Port B read data feeds the ALUSrc mux, and so the ALU's second operand.
- Write-back takes the ALU result or memory data; optional write-through bypass supports the pipelined variant.

Parameters:
- LARGURA, 32, data width of every register and data port.
- N_REG_BITS, 5, address width; register count is 2**N_REG_BITS.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports; when 0 reads see only stored state.
- SP_INIT, 32'h0000_3FFC, reset value of register 29 ($sp).
- GP_INIT, 32'h0000_1800, reset value of register 28 ($gp).

Ports:
- clk  input  1  clock; all writes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- regLe1  input  5  read address, port A (instruction rs field).
- regLe2  input  5  read address, port B (instruction rt field).
- regEscrita  input  5  write address (rd/rt, selected by RegDst upstream).
- dadosEscrita  input  32  write data (ALU result or memory data via MemtoReg mux).
- escreveReg  input  1  RegWrite from main control.
- regDbg  input  5  debug read address.
- dadosLe1  output  32  port A data, to ALU operand 1.
- dadosLe2  output  32  port B data, to ALUSrc mux and memory write data.
- dadosDbg  output  32  debug port data; never bypassed.

Behaviour:
- Storage: 32 registers of LARGURA bits.
- Reset (asynchronous, active-high):
  - rst high immediately forces every register to 0, except reg 28 = GP_INIT and reg 29 = SP_INIT.
  - Writes are ignored while rst is high.
  - The bypass is disabled while rst is high, so all outputs reflect reset contents combinationally: dadosLe1 = dadosLe2 = 0 for any address other than 28/29.
  - Release is synchronous to storage: the first write is accepted on the first rising edge after rst falls.
- Write rules:
  - On a clk rising edge with escreveReg=1 and regEscrita!=0, store dadosEscrita into regEscrita.
  - escreveReg=0 leaves all registers unchanged.
  - A write to register 0 is discarded; reg 0 always reads 0 on all three ports.
- Read rules:
  - All reads are combinational, with zero-cycle latency from address change.
  - BYPASS=1, port A: dadosLe1 = dadosEscrita when escreveReg=1, rst=0, regEscrita!=0 and regLe1==regEscrita; otherwise stored value. Port B follows the same rule with regLe2.
  - BYPASS=0: reads return stored value; the written value is visible after the edge.
  - regLe1==regLe2 is legal; both ports return identical data.
  - dadosDbg always returns stored value at regDbg.
- Simultaneous events:
  - Read and write of the same register in one cycle: the read value follows the BYPASS rule; storage updates at the edge.
  - rst asserted in the same cycle as a write: the reset wins and the write is lost.
  - rst asserted mid-cycle after the edge: the register is cleared immediately and the outputs follow.
- Widths: all data exactly LARGURA bits; no sign or zero extension inside the block. Addresses are N_REG_BITS wide; out-of-range is impossible by width.
- No X on outputs after reset. Unwritten registers read their reset value.

Decomposition:
- Shared package mips_defs holds:
  - LARGURA and N_REG_BITS defaults.
  - Register index constants: REG_ZERO=0, REG_GP=28, REG_SP=29, REG_RA=31.
  - SP_INIT and GP_INIT values.
- One natural sub-module, porta_leitura_bypass:
  - Inputs: read address, stored array value, write address, write data, escreveReg, rst.
  - Output: port data.
  - Contains the reg-0 forcing and bypass compare.
  - Instantiated twice (ports A and B), and once for debug with bypass disabled.
- Storage array and write logic stay in the top module.

Test Plan:
- Reset values: rst=1 for 2 cycles, then release; sweep regDbg 0..31 -> 0 everywhere except reg28=0x00001800 and reg29=0x00003FFC. Assert rst mid-run after writes -> same values with no clock.
- Basic write/read: write reg5=0xDEADBEEF, escreveReg=1, one edge; regLe1=5, regLe2=5 -> both 0xDEADBEEF. Then escreveReg=0 with dadosEscrita=0x1 for one edge -> still 0xDEADBEEF.
- Zero register: write reg0=0xFFFFFFFF -> dadosLe1, dadosLe2 and dadosDbg at address 0 read 0. Bypass must not forward for address 0.
- Bypass: BYPASS=1, reg7 holds 0x11, drive write reg7=0x22 with regLe1=7 -> dadosLe1=0x22 before the edge; dadosDbg=0x11 before the edge and 0x22 after. BYPASS=0 -> dadosLe1=0x11 before the edge, 0x22 after.
- Reset collision: rst rising in the same cycle as write reg9=0x55 -> reg9=0 after the edge. First write after release (reg9=0x66) -> lands on the first edge.
- ALU integration: write reg8=20 and reg9=7; regLe1=8, regLe2=9 driven into the ALU with control 6 -> ALU output 13, zero flag 0. Control 7 -> ALU output 0.
